spi_stp: RTL
============

SPI_STP -- requirements
Module: spi_stp

Interface
REQ-001 Parameter DATA_WIDTH, default 12: ADC result bits captured per frame.
REQ-002 Parameter FRAME_BITS, default 16: SCLK cycles per frame; leading FRAME_BITS-DATA_WIDTH bits are discarded.
REQ-003 Parameter NUM_CHAN, default 8: channel count for auto-scan wrap.
REQ-004 clk  input  1  SPI bit clock; block logic on rising edge, upstream shifter on falling edge.
REQ-005 n_rst  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request one conversion frame; sampled on rising clk.
REQ-007 chansel_in  input  6  channel code for the requested frame.
REQ-008 din  input  1  serial ADC data (MISO), MSB first.
REQ-009 sample_ready  input  1  consumer accepts sample this cycle.
REQ-010 clr_overrun  input  1  clears overrun flag.
REQ-011 cs_n  output  1  ADC chip select, active-low.
REQ-012 chan_en  output  1  load strobe to upstream parallel-to-serial channel shifter.
REQ-013 pts_en  output  1  shift enable to upstream shifter.
REQ-014 chansel  output  6  latched channel code driven to upstream shifter.
REQ-015 sample  output  DATA_WIDTH  last captured result.
REQ-016 sample_chan  output  6  channel code belonging to sample.
REQ-017 sample_valid  output  1  sample holds unconsumed data.
REQ-018 busy  output  1  frame in progress (state not IDLE).
REQ-019 overrun  output  1  sticky: unconsumed sample overwritten.

Function
REQ-020 FSM states IDLE, LOAD, SHIFT, DONE; all registered on rising clk.
REQ-021 IDLE: cs_n=1, chan_en=0, pts_en=0; start=1 -> latch chansel_in into chansel, go LOAD.
REQ-022 LOAD (1 cycle): cs_n=0, chan_en=1; clear bit counter and receive shift register; go SHIFT.
REQ-023 SHIFT: cs_n=0, pts_en=1; each rising edge samples din, increments bit counter 0..FRAME_BITS-1.
REQ-024 Bits with counter >= FRAME_BITS-DATA_WIDTH shift into receive register LSB end, so first kept bit ends at MSB.
REQ-025 Counter = FRAME_BITS-1 -> go DONE; counter never exceeds FRAME_BITS-1.
REQ-026 DONE (1 cycle): cs_n=1, pts_en=0; load sample <= receive register, sample_chan <= chansel, sample_valid <= 1; go IDLE.
REQ-027 Latency: start sampled at edge E0 -> sample_valid high after edge E0+FRAME_BITS+2 (18 cycles default).
REQ-028 start while busy=1 is ignored; no queuing.
REQ-029 sample_valid clears on edge where sample_valid=1 and sample_ready=1, unless DONE writes same edge.
REQ-030 DONE write with sample_valid=1 and sample_ready=0 -> overwrite, overrun <= 1.
REQ-031 DONE write with sample_valid=1 and sample_ready=1 -> new data, sample_valid stays 1, overrun unchanged.
REQ-032 clr_overrun=1 clears overrun; simultaneous set condition wins (overrun=1).
REQ-033 sample and sample_chan hold value until next DONE.

Reset
REQ-034 n_rst=0 forces IDLE immediately, including mid-frame; partial frame discarded.
REQ-035 Reset values: cs_n=1, chan_en=0, pts_en=0, chansel=0, sample=0, sample_chan=0, sample_valid=0, busy=0, overrun=0.
REQ-036 First frame after n_rst release needs a fresh start (or auto-scan, REQ-038).

Configuration
REQ-037 Macro SPI_STP_AUTOSCAN_EN undefined: no auto_scan port; frames start only on start.
REQ-038 Macro SPI_STP_AUTOSCAN_EN defined: input auto_scan (1 bit) added; in IDLE with auto_scan=1, next frame starts without start, chansel = previous chansel+1, wrapping NUM_CHAN-1 -> 0; start with chansel_in takes priority.

Verification
REQ-039 start=1 1 cycle, chansel_in=6'h05, din = 4'b0000 then 12'hA5C -> sample=12'hA5C, sample_chan=5, sample_valid 18 cycles after start edge.
REQ-040 Check upstream strobes: chan_en high exactly 1 cycle, then pts_en high exactly 16 cycles, cs_n low exactly 17 cycles.
REQ-041 Two frames (12'h123, 12'h456), sample_ready=0 -> sample=12'h456, overrun=1; clr_overrun -> overrun=0.
REQ-042 sample_ready=1 on DONE edge of second frame -> sample_valid=1, overrun=0.
REQ-043 n_rst pulse at bit 7 of frame -> outputs at reset values, no sample_valid; start re-issued -> normal frame.
REQ-044 With SPI_STP_AUTOSCAN_EN, auto_scan=1 from chansel 6 -> frames on 6, 7, 0 with back-to-back IDLE of 1 cycle.

Source files
------------

// File: rtl/spi_stp.sv
// SPI ADC frame controller: drives CS/strobes to an upstream channel shifter and captures serial results.
// Optional channel auto-scan is enabled by defining SPI_STP_AUTOSCAN_EN.
module spi_stp #(
  parameter int unsigned DATA_WIDTH = 12,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned NUM_CHAN   = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  start,
  input  logic [5:0]            chansel_in,
  input  logic                  din,
  input  logic                  sample_ready,
  input  logic                  clr_overrun,
`ifdef SPI_STP_AUTOSCAN_EN
  input  logic                  auto_scan,
`endif
  output logic                  cs_n,
  output logic                  chan_en,
  output logic                  pts_en,
  output logic [5:0]            chansel,
  output logic [DATA_WIDTH-1:0] sample,
  output logic [5:0]            sample_chan,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam int unsigned CHAN_W = 6;
  localparam int unsigned CNT_W  = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int unsigned SKIP   = FRAME_BITS - DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [CHAN_W-1:0]     chansel_q, chansel_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic [CHAN_W-1:0]     sample_chan_q, sample_chan_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  cs_n_q, cs_n_d;
  logic                  chan_en_q, chan_en_d;
  logic                  pts_en_q, pts_en_d;
  logic                  busy_q, busy_d;

  // State and output registers; reset abandons any partial frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rx_q          <= '0;
      chansel_q     <= '0;
      sample_q      <= '0;
      sample_chan_q <= '0;
      valid_q       <= 1'b0;
      overrun_q     <= 1'b0;
      cs_n_q        <= 1'b1;
      chan_en_q     <= 1'b0;
      pts_en_q      <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rx_q          <= rx_d;
      chansel_q     <= chansel_d;
      sample_q      <= sample_d;
      sample_chan_q <= sample_chan_d;
      valid_q       <= valid_d;
      overrun_q     <= overrun_d;
      cs_n_q        <= cs_n_d;
      chan_en_q     <= chan_en_d;
      pts_en_q      <= pts_en_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state logic; strobe outputs are decoded from the next state so they align with it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rx_d          = rx_q;
    chansel_d     = chansel_q;
    sample_d      = sample_q;
    sample_chan_d = sample_chan_q;
    valid_d       = valid_q;
    overrun_d     = overrun_q;

    if (valid_q && sample_ready) valid_d = 1'b0;
    if (clr_overrun)             overrun_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          chansel_d = chansel_in;
          state_d   = LOAD;
        end
`ifdef SPI_STP_AUTOSCAN_EN
        else if (auto_scan) begin
          chansel_d = (chansel_q == CHAN_W'(NUM_CHAN - 1)) ? '0 : chansel_q + CHAN_W'(1);
          state_d   = LOAD;
        end
`endif
      end
      LOAD: begin
        cnt_d   = '0;
        rx_d    = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // Leading pad bits are dropped; kept bits enter at the LSB so the first lands at the MSB.
        if (32'(cnt_q) >= SKIP) rx_d = {rx_q[DATA_WIDTH-2:0], din};
        if (cnt_q == CNT_W'(FRAME_BITS - 1)) state_d = DONE;
        else                                 cnt_d   = cnt_q + CNT_W'(1);
      end
      DONE: begin
        sample_d      = rx_q;
        sample_chan_d = chansel_q;
        valid_d       = 1'b1;
        if (valid_q && !sample_ready) overrun_d = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cs_n_d    = !((state_d == LOAD) || (state_d == SHIFT));
    chan_en_d = (state_d == LOAD);
    pts_en_d  = (state_d == SHIFT);
    busy_d    = (state_d != IDLE);
  end

  assign cs_n         = cs_n_q;
  assign chan_en      = chan_en_q;
  assign pts_en       = pts_en_q;
  assign chansel      = chansel_q;
  assign sample       = sample_q;
  assign sample_chan  = sample_chan_q;
  assign sample_valid = valid_q;
  assign busy         = busy_q;
  assign overrun      = overrun_q;

endmodule
